// File: rtl/fp_linear_decoder.sv
// Iterative decoder for the compressed {sign, exponent, significand} format:
// D = (-1)^S * F * 2^E as an OUT_W-bit two's-complement value, one shift per clock.
module fp_linear_decoder #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [EXP_W-1:0] E,
    input  logic [SIG_W-1:0] F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] D
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        NEGATE,
        OUT
    } state_t;

    state_t           state_reg;
    logic [OUT_W-1:0] acc_reg;
    logic [EXP_W-1:0] cnt_reg;
    logic             sgn_reg;
    logic [OUT_W-1:0] d_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;

    logic [OUT_W-1:0] f_ext;
    logic [OUT_W-1:0] signed_value;

    assign f_ext = {{(OUT_W-SIG_W){1'b0}}, F};

    // Negating a zero magnitude wraps back to zero, so there is no negative zero.
    assign signed_value = sgn_reg ? (~acc_reg + OUT_W'(1)) : acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sgn_reg       <= 1'b0;
            d_reg         <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sgn_reg      <= S;
                        cnt_reg      <= E;
                        acc_reg      <= f_ext;
                        in_ready_reg <= 1'b0;
                        state_reg    <= (E != '0) ? SHIFT : NEGATE;
                    end
                end
                SHIFT: begin
                    acc_reg <= acc_reg << 1;
                    cnt_reg <= cnt_reg - EXP_W'(1);
                    if (cnt_reg == EXP_W'(1)) begin
                        state_reg <= NEGATE;
                    end
                end
                NEGATE: begin
                    acc_reg       <= signed_value;
                    d_reg         <= signed_value;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    // Result is held until consumed; new inputs stay blocked meanwhile.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign D         = d_reg;

endmodule

// File: tb/tb_fp_linear_decoder.sv
// Self-checking bench for fp_linear_decoder: vector table, full code sweep,
// back-pressure and reset-abort sequences, with a queue-based scoreboard.
module tb_fp_linear_decoder;

    localparam int EXP_W = 3;
    localparam int SIG_W = 4;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [SIG_W-1:0] F;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] D;

    fp_linear_decoder #(.EXP_W(EXP_W), .SIG_W(SIG_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] f;
        logic [OUT_W-1:0] d;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        int               lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [OUT_W-1:0] model(input logic s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s) v = -v;
        return OUT_W'(v);
    endfunction

    // Accept one word, wait for the result, compare against the scoreboard head.
    task automatic do_txn(input logic s, input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] f,
                          input logic [OUT_W-1:0] req_d, input string tag);
        exp_t x;
        int   cyc;
        int   wait_cnt;
        in_valid  = 1'b1;
        S         = s;
        E         = e;
        F         = f;
        out_ready = 1'b1;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        S = $urandom_range(0, 1);
        E = EXP_W'($urandom);
        F = SIG_W'($urandom);
        sb_q.push_back('{d: req_d, lat: int'(e) + 2});
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            chk({tag, "_busy_in_ready"}, int'(in_ready), 0);
            tick();
            cyc++;
        end
        x = sb_q.pop_front();
        chk({tag, "_latency"}, cyc, x.lat);
        chk({tag, "_D"}, int'(D), int'(x.d));
        $display("txn %s S=%0d E=%0d F=%0d D=%03h lat=%0d", tag, s, e, f, D, cyc);
        tick();
        chk({tag, "_ready_after"}, int'(in_ready), 1);
        chk({tag, "_valid_after"}, int'(out_valid), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        int seen;
        vecs[0] = '{s: 1'b0, e: 3'd0, f: 4'b1010, d: 12'h00A};
        vecs[1] = '{s: 1'b0, e: 3'd7, f: 4'b1111, d: 12'h780};
        vecs[2] = '{s: 1'b1, e: 3'd7, f: 4'b1111, d: 12'h880};
        vecs[3] = '{s: 1'b1, e: 3'd2, f: 4'b0011, d: 12'hFF4};
        vecs[4] = '{s: 1'b1, e: 3'd3, f: 4'b0000, d: 12'h000};
        vecs[5] = '{s: 1'b0, e: 3'd1, f: 4'b0001, d: 12'h002};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S = 1'b0; E = '0; F = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_D", int'(D), 0);

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].d, $sformatf("vec%0d", i));
        end

        for (int c = 0; c < 256; c++) begin
            logic s;
            int   e;
            int   f;
            s = c[7];
            e = (c >> 4) & 7;
            f = c & 15;
            do_txn(s, EXP_W'(e), SIG_W'(f), model(s, e, f), $sformatf("sweep%0d", c));
        end

        // Back-pressure: result held in OUT while inputs thrash.
        in_valid = 1'b1; S = 1'b0; E = 3'd4; F = 4'b0101; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("hold_latency", cyc, 6);
        for (int k = 0; k < 6; k++) begin
            in_valid = $urandom_range(0, 1);
            S = $urandom_range(0, 1);
            E = EXP_W'($urandom);
            F = SIG_W'($urandom);
            tick();
            chk("hold_D", int'(D), 12'h050);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        $display("txn hold S=0 E=4 F=5 D=%03h held 6 cycles", D);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_ready", int'(in_ready), 1);
        chk("hold_release_D", int'(D), 12'h050);

        // Reset during SHIFT discards the transaction.
        in_valid = 1'b1; S = 1'b0; E = 3'd5; F = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_D", int'(D), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        $display("txn abort S=0 E=5 F=15 discarded");
        do_txn(1'b0, 3'd1, 4'b0001, 12'h002, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
